// File: rtl/idu_stage.sv
// idu_stage: RV32I decode stage between fetch and execute, single-entry output register.
// Latency: 1 cycle from accept (s_valid && s_ready) to m_valid.
// Backpressure: s_ready = !m_valid || m_ready; a stalled bundle holds every m_* output stable.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   s_valid/s_ready     fetch-side handshake; s_inst/s_pc are the instruction and its PC
//   m_valid/m_ready     execute-side handshake
//   m_pc, m_rs1/2, m_rd registered PC and raw register index fields
//   m_imm               sign-extended immediate (0 for R-type and unknown opcodes)
//   m_alu_op, m_alu_src_imm, m_alu_src_pc   ALU control
//   m_reg_wen, m_mem_ren, m_mem_wen, m_mem_funct3   writeback / memory control
//   m_is_branch, m_is_jal, m_is_jalr, m_is_lui, m_ebreak, m_illegal   instruction class flags
module idu_stage #(
  parameter int XLEN  = 32,  // only 32 is supported
  parameter bit RV32E = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [31:0]     s_inst,
  input  logic [XLEN-1:0] s_pc,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [XLEN-1:0] m_pc,
  output logic [4:0]      m_rs1,
  output logic [4:0]      m_rs2,
  output logic [4:0]      m_rd,
  output logic [XLEN-1:0] m_imm,
  output logic [3:0]      m_alu_op,
  output logic            m_alu_src_imm,
  output logic            m_alu_src_pc,
  output logic            m_reg_wen,
  output logic            m_mem_ren,
  output logic            m_mem_wen,
  output logic [2:0]      m_mem_funct3,
  output logic            m_is_branch,
  output logic            m_is_jal,
  output logic            m_is_jalr,
  output logic            m_is_lui,
  output logic            m_ebreak,
  output logic            m_illegal
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            alu_src_imm;
    logic            alu_src_pc;
    logic            reg_wen;
    logic            mem_ren;
    logic            mem_wen;
    logic [2:0]      mem_funct3;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            is_lui;
    logic            ebreak;
    logic            illegal;
  } bundle_t;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = s_inst[6:0];
  assign rd     = s_inst[11:7];
  assign funct3 = s_inst[14:12];
  assign rs1    = s_inst[19:15];
  assign rs2    = s_inst[24:20];
  assign funct7 = s_inst[31:25];

  // Immediate formats
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{s_inst[31]}}, s_inst[31:20]};
  assign imm_s = {{20{s_inst[31]}}, s_inst[31:25], s_inst[11:7]};
  assign imm_b = {{19{s_inst[31]}}, s_inst[31], s_inst[7], s_inst[30:25], s_inst[11:8], 1'b0};
  assign imm_u = {s_inst[31:12], 12'b0};
  assign imm_j = {{11{s_inst[31]}}, s_inst[31], s_inst[19:12], s_inst[20], s_inst[30:21], 1'b0};

  // funct3 -> ALU op with funct7[5] ignored; SUB/SRA are patched in per opcode
  logic [3:0] alu_base;

  always_comb begin
    alu_base = ALU_ADD;
    case (funct3)
      3'd0:    alu_base = ALU_ADD;
      3'd1:    alu_base = ALU_SLL;
      3'd2:    alu_base = ALU_SLT;
      3'd3:    alu_base = ALU_SLTU;
      3'd4:    alu_base = ALU_XOR;
      3'd5:    alu_base = ALU_SRL;
      3'd6:    alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
  end

  // Raw decode, before illegal gating
  logic [3:0]  d_alu_op;
  logic [31:0] d_imm;
  logic [2:0]  d_funct3;
  logic        d_src_imm, d_src_pc, d_wen, d_ren, d_mwen;
  logic        d_br, d_jal, d_jalr, d_lui, d_ebreak, d_ill;
  logic        use_rs1, use_rs2, use_rd;

  always_comb begin
    d_alu_op  = ALU_ADD;
    d_imm     = 32'd0;
    d_funct3  = 3'd0;
    d_src_imm = 1'b0;
    d_src_pc  = 1'b0;
    d_wen     = 1'b0;
    d_ren     = 1'b0;
    d_mwen    = 1'b0;
    d_br      = 1'b0;
    d_jal     = 1'b0;
    d_jalr    = 1'b0;
    d_lui     = 1'b0;
    d_ebreak  = 1'b0;
    d_ill     = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;

    case (opcode)
      OPC_LUI: begin
        d_imm = imm_u; d_src_imm = 1'b1; d_wen = 1'b1; d_lui = 1'b1; use_rd = 1'b1;
      end
      OPC_AUIPC: begin
        d_imm = imm_u; d_src_imm = 1'b1; d_src_pc = 1'b1; d_wen = 1'b1; use_rd = 1'b1;
      end
      OPC_JAL: begin
        d_imm = imm_j; d_src_imm = 1'b1; d_src_pc = 1'b1; d_wen = 1'b1; d_jal = 1'b1;
        use_rd = 1'b1;
      end
      OPC_JALR: begin
        d_imm = imm_i; d_src_imm = 1'b1; d_wen = 1'b1; d_jalr = 1'b1;
        use_rs1 = 1'b1; use_rd = 1'b1;
        d_ill = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        d_imm = imm_b; d_alu_op = ALU_SUB; d_br = 1'b1; d_funct3 = funct3;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        d_ill = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_LOAD: begin
        d_imm = imm_i; d_src_imm = 1'b1; d_wen = 1'b1; d_ren = 1'b1; d_funct3 = funct3;
        use_rs1 = 1'b1; use_rd = 1'b1;
        d_ill = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        d_imm = imm_s; d_src_imm = 1'b1; d_mwen = 1'b1; d_funct3 = funct3;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        d_ill = (funct3 >= 3'd3);
      end
      OPC_OP_IMM: begin
        d_imm = imm_i; d_src_imm = 1'b1; d_wen = 1'b1; d_alu_op = alu_base;
        use_rs1 = 1'b1; use_rd = 1'b1;
        // only the shift-immediates constrain the upper immediate bits
        if (funct3 == 3'd1) begin
          d_ill = (funct7 != 7'h00);
        end else if (funct3 == 3'd5) begin
          if (funct7 == 7'h20) d_alu_op = ALU_SRA;
          else                 d_ill    = (funct7 != 7'h00);
        end
      end
      OPC_OP: begin
        d_wen = 1'b1; d_alu_op = alu_base;
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        if (funct7 == 7'h20) begin
          if      (funct3 == 3'd0) d_alu_op = ALU_SUB;
          else if (funct3 == 3'd5) d_alu_op = ALU_SRA;
          else                     d_ill    = 1'b1;
        end else begin
          d_ill = (funct7 != 7'h00);
        end
      end
      OPC_MISC_MEM: begin
        // FENCE: in-order single-issue pipe, nothing to do downstream
      end
      OPC_SYSTEM: begin
        d_imm    = imm_i;
        d_ebreak = (s_inst == INST_EBREAK);
        d_ill    = !((s_inst == INST_ECALL) || (s_inst == INST_EBREAK));
      end
      default: d_ill = 1'b1;
    endcase

    // Only fields the format actually uses are register indices
    if (RV32E && ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4])))
      d_ill = 1'b1;
  end

  // Assemble the bundle; an illegal instruction keeps only pc/indices/imm plus the illegal flag
  bundle_t dec;

  always_comb begin
    dec         = '0;
    dec.pc      = s_pc;
    dec.rs1     = rs1;
    dec.rs2     = rs2;
    dec.rd      = rd;
    dec.imm     = d_imm;
    dec.illegal = d_ill;
    if (!d_ill) begin
      dec.alu_op      = d_alu_op;
      dec.alu_src_imm = d_src_imm;
      dec.alu_src_pc  = d_src_pc;
      dec.reg_wen     = d_wen && (rd != 5'd0);
      dec.mem_ren     = d_ren;
      dec.mem_wen     = d_mwen;
      dec.mem_funct3  = d_funct3;
      dec.is_branch   = d_br;
      dec.is_jal      = d_jal;
      dec.is_jalr     = d_jalr;
      dec.is_lui      = d_lui;
      dec.ebreak      = d_ebreak;
    end
  end

  // Output register
  bundle_t out_q;
  logic    valid_q;
  logic    accept;

  assign s_ready = !valid_q || m_ready;
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      out_q   <= dec;
    end else if (m_ready) begin
      valid_q <= 1'b0;  // drained; data holds its last value
    end
  end

  assign m_valid       = valid_q;
  assign m_pc          = out_q.pc;
  assign m_rs1         = out_q.rs1;
  assign m_rs2         = out_q.rs2;
  assign m_rd          = out_q.rd;
  assign m_imm         = out_q.imm;
  assign m_alu_op      = out_q.alu_op;
  assign m_alu_src_imm = out_q.alu_src_imm;
  assign m_alu_src_pc  = out_q.alu_src_pc;
  assign m_reg_wen     = out_q.reg_wen;
  assign m_mem_ren     = out_q.mem_ren;
  assign m_mem_wen     = out_q.mem_wen;
  assign m_mem_funct3  = out_q.mem_funct3;
  assign m_is_branch   = out_q.is_branch;
  assign m_is_jal      = out_q.is_jal;
  assign m_is_jalr     = out_q.is_jalr;
  assign m_is_lui      = out_q.is_lui;
  assign m_ebreak      = out_q.ebreak;
  assign m_illegal     = out_q.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// tb_idu_stage: scoreboard bench for idu_stage.
// Expected bundles are pushed on accept and compared while they sit on the output.
// Covers reset, streaming, a 3-cycle stall, random handshakes and reset while stalled.
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [31:0] s_inst, s_pc, m_pc, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_alu_op;
  logic        m_alu_src_imm, m_alu_src_pc, m_reg_wen, m_mem_ren, m_mem_wen;
  logic [2:0]  m_mem_funct3;
  logic        m_is_branch, m_is_jal, m_is_jalr, m_is_lui, m_ebreak, m_illegal;

  always #5 clk = ~clk;

  idu_stage #(.XLEN(32), .RV32E(1'b0)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_inst(s_inst), .s_pc(s_pc),
    .m_valid(m_valid), .m_ready(m_ready), .m_pc(m_pc),
    .m_rs1(m_rs1), .m_rs2(m_rs2), .m_rd(m_rd), .m_imm(m_imm),
    .m_alu_op(m_alu_op), .m_alu_src_imm(m_alu_src_imm), .m_alu_src_pc(m_alu_src_pc),
    .m_reg_wen(m_reg_wen), .m_mem_ren(m_mem_ren), .m_mem_wen(m_mem_wen),
    .m_mem_funct3(m_mem_funct3), .m_is_branch(m_is_branch), .m_is_jal(m_is_jal),
    .m_is_jalr(m_is_jalr), .m_is_lui(m_is_lui), .m_ebreak(m_ebreak), .m_illegal(m_illegal)
  );

  // {alu_op, src_imm, src_pc, reg_wen, mem_ren, mem_wen, funct3, br, jal, jalr, lui, ebreak, illegal}
  logic [17:0] dut_ctl;
  assign dut_ctl = {m_alu_op, m_alu_src_imm, m_alu_src_pc, m_reg_wen, m_mem_ren, m_mem_wen,
                    m_mem_funct3, m_is_branch, m_is_jal, m_is_jalr, m_is_lui, m_ebreak, m_illegal};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [17:0] ctl;
  } exp_t;

  localparam int NV = 18;
  logic [31:0] vinst [NV];
  exp_t        vexp  [NV];
  exp_t        sbq   [$];
  logic        exp_valid;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] mk(input int alu, input bit simm, input bit spc, input bit wen,
                                     input bit ren, input bit mwen, input int f3, input bit br,
                                     input bit jal, input bit jalr, input bit lui, input bit eb,
                                     input bit ill);
    logic [3:0] a;
    logic [2:0] f;
    a = alu[3:0];
    f = f3[2:0];
    return {a, simm, spc, wen, ren, mwen, f, br, jal, jalr, lui, eb, ill};
  endfunction

  task automatic set_vec(input int i, input logic [31:0] inst, input logic [31:0] imm,
                         input int rs1, input int rs2, input int rd, input logic [17:0] ctl);
    vinst[i]     = inst;
    vexp[i].pc   = 32'd0;
    vexp[i].imm  = imm;
    vexp[i].rs1  = 5'(rs1);
    vexp[i].rs2  = 5'(rs2);
    vexp[i].rd   = 5'(rd);
    vexp[i].ctl  = ctl;
  endtask

  task automatic compare_head(input exp_t e);
    check("m_pc",  m_pc,  e.pc);
    check("m_imm", m_imm, e.imm);
    check("m_rs1", {27'd0, m_rs1}, {27'd0, e.rs1});
    check("m_rs2", {27'd0, m_rs2}, {27'd0, e.rs2});
    check("m_rd",  {27'd0, m_rd},  {27'd0, e.rd});
    check("m_ctl", {14'd0, dut_ctl}, {14'd0, e.ctl});
  endtask

  // rnd=0: m_ready low only in cycles 4..6 (while the beq at index 3 is on the output)
  task automatic run_stream(input bit rnd, input logic [31:0] pc_base);
    int   idx = 0;
    int   cyc = 0;
    bit   acc = 1'b0;
    exp_t e;
    while ((idx < NV || sbq.size() != 0) && cyc < 500) begin
      @(negedge clk);
      if (acc) s_valid = 1'b0;
      if (!s_valid && idx < NV && (!rnd || $urandom_range(0, 3) != 0)) begin
        s_valid = 1'b1;
        s_inst  = vinst[idx];
        s_pc    = pc_base + 32'(idx * 4);
      end
      m_ready = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 4 && cyc <= 6);
      #1;
      check("m_valid", {31'd0, m_valid}, {31'd0, exp_valid});
      check("s_ready", {31'd0, s_ready}, {31'd0, (!exp_valid || m_ready)});
      if (m_valid && sbq.size() != 0) compare_head(sbq[0]);
      if (exp_valid && m_ready && sbq.size() != 0) void'(sbq.pop_front());
      acc = s_valid && (!exp_valid || m_ready);
      if (acc) begin
        e    = vexp[idx];
        e.pc = s_pc;
        sbq.push_back(e);
        idx++;
      end
      exp_valid = acc || (exp_valid && !m_ready);
      cyc++;
    end
    s_valid = 1'b0;
    check("stream_sent",  32'(idx), 32'(NV));
    check("stream_drain", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    s_valid = 1'b0; s_inst = 32'd0; s_pc = 32'd0; m_ready = 1'b0; exp_valid = 1'b0;

    set_vec(0,  32'h00500093, 32'd5,         0, 5, 1,  mk(0,1,0,1,0,0,0,0,0,0,0,0,0)); // addi x1,x0,5
    set_vec(1,  32'h0040A103, 32'd4,         1, 4, 2,  mk(0,1,0,1,1,0,2,0,0,0,0,0,0)); // lw x2,4(x1)
    set_vec(2,  32'h0020A423, 32'd8,         1, 2, 8,  mk(0,1,0,0,0,1,2,0,0,0,0,0,0)); // sw x2,8(x1)
    set_vec(3,  32'hFE000EE3, 32'hFFFFFFFC,  0, 0, 29, mk(1,0,0,0,0,0,0,1,0,0,0,0,0)); // beq x0,x0,-4
    set_vec(4,  32'h00100073, 32'd1,         0, 1, 0,  mk(0,0,0,0,0,0,0,0,0,0,0,1,0)); // ebreak
    set_vec(5,  32'hFFFFFFFF, 32'd0,         31,31,31, mk(0,0,0,0,0,0,0,0,0,0,0,0,1)); // unknown opcode
    set_vec(6,  32'h123452B7, 32'h12345000,  8, 3, 5,  mk(0,1,0,1,0,0,0,0,0,0,1,0,0)); // lui x5
    set_vec(7,  32'hFFFFF317, 32'hFFFFF000,  31,31,6,  mk(0,1,1,1,0,0,0,0,0,0,0,0,0)); // auipc x6
    set_vec(8,  32'hFF9FF0EF, 32'hFFFFFFF8,  31,25,1,  mk(0,1,1,1,0,0,0,0,1,0,0,0,0)); // jal x1,-8
    set_vec(9,  32'h00008067, 32'd0,         1, 0, 0,  mk(0,1,0,0,0,0,0,0,0,1,0,0,0)); // jalr x0,0(x1)
    set_vec(10, 32'h402081B3, 32'd0,         1, 2, 3,  mk(1,0,0,1,0,0,0,0,0,0,0,0,0)); // sub x3,x1,x2
    set_vec(11, 32'h4030D213, 32'h00000403,  1, 3, 4,  mk(7,1,0,1,0,0,0,0,0,0,0,0,0)); // srai x4,x1,3
    set_vec(12, 32'h40309213, 32'h00000403,  1, 3, 4,  mk(0,0,0,0,0,0,0,0,0,0,0,0,1)); // slli, funct7=0x20
    set_vec(13, 32'h4020C1B3, 32'd0,         1, 2, 3,  mk(0,0,0,0,0,0,0,0,0,0,0,0,1)); // xor with 0x20
    set_vec(14, 32'h0040B103, 32'd4,         1, 4, 2,  mk(0,0,0,0,0,0,0,0,0,0,0,0,1)); // load funct3=3
    set_vec(15, 32'h00208033, 32'd0,         1, 2, 0,  mk(0,0,0,0,0,0,0,0,0,0,0,0,0)); // add x0: no wen
    set_vec(16, 32'h00209863, 32'd16,        1, 2, 16, mk(1,0,0,0,0,0,1,1,0,0,0,0,0)); // bne x1,x2,+16
    set_vec(17, 32'h00000073, 32'd0,         0, 0, 0,  mk(0,0,0,0,0,0,0,0,0,0,0,0,0)); // ecall

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_m_pc",    m_pc,  32'd0);
    check("rst_m_imm",   m_imm, 32'd0);
    check("rst_regs",    {17'd0, m_rs1, m_rs2, m_rd}, 32'd0);
    check("rst_ctl",     {14'd0, dut_ctl}, 32'd0);
    @(negedge clk);
    check("idle_m_valid", {31'd0, m_valid}, 32'd0);

    run_stream(1'b0, 32'h8000_0000);
    run_stream(1'b1, 32'h9000_0000);

    // Reset while a bundle is stalled on the output
    @(negedge clk);
    s_valid = 1'b1; s_inst = vinst[0]; s_pc = 32'hA000_0000; m_ready = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    check("pre_rst_m_valid", {31'd0, m_valid}, 32'd1);
    check("pre_rst_m_pc",    m_pc, 32'hA000_0000);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("async_rst_m_pc",    m_pc, 32'd0);
    check("async_rst_s_ready", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_valid = 1'b0;
    sbq.delete();
    run_stream(1'b0, 32'hB000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/idu_stage.md
Name: idu_stage

Overview:
- Instruction decode stage; sits directly downstream of the fetch unit.
- Accepts a fetched instruction word and its PC over a valid/ready handshake.
- Decodes RV32I into register indices, a sign-extended immediate and control flags.
- Holds the result in a single-entry output register for the execute stage, with backpressure.

Parameters:
- XLEN, 32, data/address width (only 32 supported).
- RV32E, 0, if 1 then any rs1/rs2/rd index >= 16 flags illegal.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  upstream (fetch) has a valid instruction.
- s_ready  output  1  this stage can accept this cycle.
- s_inst  input  32  instruction word.
- s_pc  input  32  PC of s_inst.
- m_valid  output  1  decoded bundle valid for execute.
- m_ready  input  1  execute accepts the bundle.
- m_pc  output  32  registered PC.
- m_rs1, m_rs2, m_rd  output  5 each  register indices.
- m_imm  output  32  sign-extended immediate.
- m_alu_op  output  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- m_alu_src_imm  output  1  ALU operand B is m_imm.
- m_alu_src_pc  output  1  ALU operand A is m_pc (AUIPC, JAL).
- m_reg_wen  output  1  writes rd.
- m_mem_ren, m_mem_wen  output  1 each  load / store.
- m_mem_funct3  output  3  funct3 passed through for loads, stores and branches.
- m_is_branch, m_is_jal, m_is_jalr, m_is_lui  output  1 each.
- m_ebreak  output  1  instruction is 0x00100073.
- m_illegal  output  1  undecodable instruction.

Behaviour:
- Reset (async assert, sync release): m_valid=0; every m_* data output=0.
- Handshake:
  - s_ready = !m_valid || m_ready (combinational; no path from s_valid).
  - Accept when s_valid && s_ready. Next edge: register decode of s_inst/s_pc, m_valid=1.
  - m_valid && m_ready && !(s_valid && s_ready): next edge m_valid=0; data outputs hold their last value.
  - Simultaneous drain and accept: the new bundle replaces the old one with no bubble. Throughput is 1 per cycle.
  - While m_valid && !m_ready: every m_* output holds stable, and s_ready=0.
- Latency: exactly 1 cycle from accept to m_valid.
- Decode is purely combinational from s_inst and is captured only on accept.
- Immediates, by opcode:
  - I type (LOAD, OP-IMM, JALR, SYSTEM): inst[31:20] sign-extended.
  - S type: {inst[31:25], inst[11:7]} sign-extended.
  - B type: {inst[31], inst[7], inst[30:25], inst[11:8], 0} sign-extended.
  - U type: {inst[31:12], 12'b0}.
  - J type: {inst[31], inst[19:12], inst[20], inst[30:21], 0} sign-extended.
  - R type: 0.
- ALU op selection:
  - OP: from funct3, with funct7[5] selecting SUB or SRA.
  - OP-IMM: funct7[5] is honoured for SRAI only.
  - LOAD, STORE, JAL, JALR, AUIPC, LUI: ADD.
  - BRANCH: SUB.
- m_reg_wen=1 for LUI, AUIPC, JAL, JALR, LOAD, OP, OP-IMM. It is forced to 0 when rd=0.
- Illegal (m_illegal=1) when any of these hold:
  - unknown opcode;
  - LOAD funct3 in {3,6,7};
  - STORE funct3 >= 3;
  - BRANCH funct3 in {2,3};
  - JALR funct3 != 0;
  - OP funct7 not in {0x00, 0x20};
  - 0x20 used with a funct3 other than ADD/SRL;
  - SLLI/SRLI/SRAI with a bad funct7;
  - SYSTEM other than ECALL/EBREAK;
  - RV32E index violation.
- When m_illegal=1: m_reg_wen, m_mem_ren, m_mem_wen and all m_is_* flags are 0. m_pc is still valid so the trap PC is available.
- Reset mid-operation: a pending bundle is discarded immediately and m_valid drops asynchronously.

Test Plan:
- Reset release, s_valid=0 -> m_valid=0, s_ready=1, all outputs 0.
- s_inst=0x00500093 (addi x1,x0,5), s_pc=0x80000000 -> one cycle later:
  - m_valid=1, m_rd=1, m_rs1=0, m_imm=5;
  - m_alu_op=ADD, m_alu_src_imm=1, m_reg_wen=1, m_pc=0x80000000.
- Back-to-back, no stall:
  - 0x0040A103 (lw x2,4(x1)) then 0x0020A423 (sw x2,8(x1)) on consecutive cycles, m_ready=1.
  - -> lw: m_mem_ren=1, m_imm=4, m_rd=2, m_mem_funct3=2.
  - -> sw: m_mem_wen=1, m_reg_wen=0, m_imm=8, m_rs2=2.
  - -> no bubble between them.
- Backpressure: 0xFE000EE3 (beq x0,x0,-4) accepted, m_ready=0 for 3 cycles:
  - -> s_ready=0, outputs stable: m_imm=0xFFFFFFFC, m_is_branch=1, m_alu_op=SUB.
  - -> m_ready=1 then drains and accepts the next instruction in the same cycle.
- 0x00100073 -> m_ebreak=1, m_illegal=0. 0xFFFFFFFF -> m_illegal=1, all write and flag outputs 0.
- Assert rst while m_valid=1 and m_ready=0 -> m_valid=0 before the next clock edge. After release the stage accepts normally.
